// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine slice.
//   state_t            : controller state encoding (ACCUM, VEND, CHANGE)
//   NICKEL_V/DIME_V/
//   QUARTER_V          : coin values in nickel units
package vending_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [2:0] NICKEL_V  = 3'd1;
    localparam logic [2:0] DIME_V    = 3'd2;
    localparam logic [2:0] QUARTER_V = 3'd5;

endpackage

// File: rtl/vending_coin_decode.sv
// Combinational coin decoder.
// Ports:
//   nickel, dime, quarter : coin pulses from the acceptor (inputs)
//   coinValue             : value of the coin in nickel units, 0 if none/invalid
//   coinValid             : exactly one coin input is high
//   coinMulti             : two or more coin inputs are high (all rejected)
module vending_coin_decode
    import vending_pkg::*;
(
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    output logic [2:0] coinValue,
    output logic       coinValid,
    output logic       coinMulti
);

    // Only a single asserted coin line is a usable coin; any overlap is
    // treated as a jam and rejected as a whole.
    always_comb begin
        coinValue = 3'd0;
        coinValid = 1'b0;
        coinMulti = 1'b0;
        case ({quarter, dime, nickel})
            3'b000: ;
            3'b001: begin coinValue = NICKEL_V;  coinValid = 1'b1; end
            3'b010: begin coinValue = DIME_V;    coinValid = 1'b1; end
            3'b100: begin coinValue = QUARTER_V; coinValid = 1'b1; end
            default: coinMulti = 1'b1;
        endcase
    end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: accumulates credit, releases one product
// under a valid/ready handshake, then pays out change or a refund one nickel
// at a time under a second valid/ready handshake.
// Parameters:
//   PRICE    : item price in nickel units
//   CREDIT_W : width of the credit/change register
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   nickel, dime, quarter : coin pulses
//   cancel                : refund request (honoured only while accumulating)
//   dispense/dispense_ready       : product-release handshake
//   change_valid/change_ready     : one-nickel change handshake
//   credit                : current credit or remaining change
//   coin_reject           : one-cycle pulse after a cycle with a refused coin
//   busy                  : high while vending or paying change
module vending_machine_param
    import vending_pkg::*;
#(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    output logic                dispense,
    input  logic                dispense_ready,
    output logic                change_valid,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                busy
);

    // The largest credit ever held is PRICE-1 plus a quarter, so the
    // register must hold PRICE+4 without wrapping.
    generate
        if (PRICE < 1 || PRICE + 4 >= (1 << CREDIT_W)) begin : g_bad_params
            $error("vending_machine_param: PRICE out of range for CREDIT_W");
        end
    endgenerate

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;

    logic [2:0]          coinValue;
    logic                coinValid;
    logic                coinMulti;
    logic [CREDIT_W-1:0] creditSum;
    logic                creditZero;

    vending_coin_decode u_decode (
        .nickel    (nickel),
        .dime      (dime),
        .quarter   (quarter),
        .coinValue (coinValue),
        .coinValid (coinValid),
        .coinMulti (coinMulti)
    );

    assign creditSum  = credit_q + CREDIT_W'(coinValue);
    assign creditZero = (credit_q == '0);

    // State, credit and reject-pulse registers; reset abandons any pending
    // product or change.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ACCUM;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    // Next-state and credit arithmetic. A coin is refused whenever it is
    // malformed, arrives alongside a cancel, or arrives while busy.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            ACCUM: begin
                if (cancel) begin
                    reject_d = coinValid | coinMulti;
                    if (!creditZero) begin
                        state_d = CHANGE;
                    end
                end else if (coinMulti) begin
                    reject_d = 1'b1;
                end else if (coinValid) begin
                    if (creditSum >= PRICE_C) begin
                        credit_d = creditSum - PRICE_C;
                        state_d  = VEND;
                    end else begin
                        credit_d = creditSum;
                    end
                end
            end
            VEND: begin
                reject_d = coinValid | coinMulti;
                if (dispense_ready) begin
                    state_d = creditZero ? ACCUM : CHANGE;
                end
            end
            CHANGE: begin
                reject_d = coinValid | coinMulti;
                if (change_ready) begin
                    credit_d = credit_q - 1'b1;
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = ACCUM;
                    end
                end
            end
            default: begin
                state_d  = ACCUM;
                credit_d = '0;
            end
        endcase
    end

    assign dispense     = (state_q == VEND);
    assign change_valid = (state_q == CHANGE);
    assign busy         = (state_q != ACCUM);
    assign credit       = credit_q;
    assign coin_reject  = reject_q;

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
Parametrised coin-accepting vending FSM. It accumulates credit from nickel, dime and quarter inputs against a configurable price. It holds dispense under a valid/ready handshake, then returns change or a cancelled credit one nickel at a time over a valid/ready change channel. It sits between the coin-acceptor front end and the product/change actuators.

Parameters:
PRICE, 4, item price in nickel units (5 cents each); legal range 1 to 2^CREDIT_W-5
CREDIT_W, 4, width of credit/change register in nickel units; elaboration error if PRICE+4 >= 2^CREDIT_W

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high; clock clock
nickel  input  1  coin pulse, value 1 unit
dime  input  1  coin pulse, value 2 units
quarter  input  1  coin pulse, value 5 units
cancel  input  1  request refund of accumulated credit
dispense  output  1  product-release valid
dispense_ready  input  1  actuator accepts dispense
change_valid  output  1  one nickel of change/refund offered
change_ready  input  1  change actuator accepts one nickel
credit  output  CREDIT_W  current credit or remaining change, nickel units
coin_reject  output  1  one-cycle pulse: a coin this cycle was not accepted
busy  output  1  high in VEND or CHANGE

Behaviour:
- Reset: state ACCUM, credit 0, and dispense, change_valid, coin_reject, busy all 0. Reset mid-VEND/CHANGE abandons pending product/change.
- All outputs registered or decoded from registered state; no input-to-output combinational path.
- Coin decode: exactly one of nickel/dime/quarter high gives a valid coin of value 1/2/5. Two or more high: all rejected, coin_reject=1 next cycle, credit unchanged.
- ACCUM:
  - cancel=1 and credit>0: go to CHANGE, credit retained as refund. Any coin that cycle is rejected (coin_reject next cycle).
  - cancel=1 and credit==0: no-op. A simultaneous coin is still rejected.
  - Valid coin, no cancel, sum=credit+value:
    - sum<PRICE: credit<=sum, stay ACCUM.
    - sum>=PRICE: credit<=sum-PRICE (change owed), go to VEND.
- VEND: dispense=1, held until the cycle dispense_ready=1. On that cycle:
  - credit>0: go to CHANGE.
  - credit==0: go to ACCUM.
  - Latency: dispense rises the cycle after the accepting coin.
- CHANGE: change_valid=1. Each cycle with change_ready=1, credit decrements by 1. On the handshake with credit==1, go to ACCUM (credit 0, change_valid low the next cycle).
- In VEND and CHANGE:
  - Any coin input: coin_reject=1 next cycle, credit unaffected.
  - cancel is ignored.
- coin_reject is a single-cycle pulse per offending cycle. Back-to-back offending cycles give back-to-back pulses.
- No credit wrap: parameter check guarantees max credit PRICE-1+5 fits in CREDIT_W.
- dispense and change_valid are never high together.

Decomposition:
- Package vending_pkg:
  - state enum {ACCUM, VEND, CHANGE}, 2-bit
  - coin value constants NICKEL_V=1, DIME_V=2, QUARTER_V=5
- Sub-module vending_coin_decode (combinational): coin inputs -> value[2:0], coin_valid, coin_multi.
- Top holds the state register, credit arithmetic and handshakes.

Test Plan:
1. PRICE=4, reset, four single-cycle nickels -> credit 1,2,3 then dispense=1 the cycle after the 4th; dispense_ready=1 -> ACCUM, credit 0, change_valid never high.
2. Quarter into empty machine -> VEND with credit=1; dispense_ready held 0 for 5 cycles keeps dispense=1, busy=1. Then ready -> change_valid=1 for exactly one handshake -> credit 0, ACCUM.
3. Dime then cancel -> CHANGE with credit 2; change_ready toggled 1,0,1 -> credit 2,1,1,0 with exactly two handshakes; dispense never asserted.
4. nickel and dime high in the same cycle -> coin_reject=1 next cycle, credit unchanged. Cancel+nickel with credit 0 -> coin_reject=1, credit 0, stays ACCUM.
5. Nickel during VEND and dime during CHANGE -> coin_reject pulse each, credit/change count unaffected. Cancel in VEND ignored.
6. Reset asserted during CHANGE with credit 3 -> next cycle change_valid=0, credit=0, busy=0. A following quarter behaves as in test 2.
